// File: rtl/operand_fetch_if.sv
// Bundle between decode/writeback and the operand fetch stage, plus the
// registered operand bundle handed to execute.
interface operand_fetch_if #(
  parameter int word_size = 32
);
  logic                 in_valid;
  logic [3:0]           op_code;
  logic [3:0]           dest;
  logic [3:0]           op_reg1;
  logic                 imm_or_reg;
  logic [3:0]           op_reg2;
  logic [7:0]           sft_reg;
  logic [3:0]           sft_imm;
  logic [7:0]           imm;
  logic                 wb_en;
  logic [3:0]           wb_addr;
  logic [word_size-1:0] wb_data;
  logic                 ex_stall;
  logic                 ex_valid;
  logic [3:0]           ex_op_code;
  logic [3:0]           ex_dest;
  logic [word_size-1:0] ex_a;
  logic [word_size-1:0] ex_b;
  logic                 ex_shift_carry;

  modport master (
    output in_valid, op_code, dest, op_reg1, imm_or_reg, op_reg2, sft_reg,
           sft_imm, imm, wb_en, wb_addr, wb_data, ex_stall,
    input  ex_valid, ex_op_code, ex_dest, ex_a, ex_b, ex_shift_carry
  );

  modport slave (
    input  in_valid, op_code, dest, op_reg1, imm_or_reg, op_reg2, sft_reg,
           sft_imm, imm, wb_en, wb_addr, wb_data, ex_stall,
    output ex_valid, ex_op_code, ex_dest, ex_a, ex_b, ex_shift_carry
  );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: 16x32 register file with writeback bypass, barrel
// shifter / rotated immediate for operand B, and the execute pipeline register.
module operand_fetch #(
  parameter int word_size = 32,
  parameter int reg_count = 16
) (
  input logic            clk,
  input logic            rst,
  operand_fetch_if.slave bus
);

  logic [word_size-1:0] regs [reg_count];

  // Flop-based file: reset must load a distinct value into every entry.
  generate
    for (genvar gi = 0; gi < reg_count; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)
          regs[gi] <= word_size'(gi * 16);
        else if (bus.wb_en && bus.wb_addr == 4'(gi))
          regs[gi] <= bus.wb_data;
      end
    end
  endgenerate

  logic [word_size-1:0] a_val;
  logic [word_size-1:0] src;
  logic [word_size-1:0] imm_ext;
  logic [word_size-1:0] b_val;
  logic                 c_val;
  logic [4:0]           amt;
  logic [4:0]           rot;
  logic                 unused_sft_bit;

  assign unused_sft_bit = bus.sft_reg[0];

  always_comb begin
    a_val   = (bus.wb_en && bus.wb_addr == bus.op_reg1) ? bus.wb_data : regs[bus.op_reg1];
    src     = (bus.wb_en && bus.wb_addr == bus.op_reg2) ? bus.wb_data : regs[bus.op_reg2];
    imm_ext = {{(word_size-8){1'b0}}, bus.imm};
    amt     = bus.sft_reg[7:3];
    rot     = {bus.sft_imm, 1'b0};
    b_val   = src;
    c_val   = 1'b0;
    if (bus.imm_or_reg) begin
      b_val = (imm_ext >> rot) | (imm_ext << (6'd32 - {1'b0, rot}));
      c_val = (rot != 5'd0) & b_val[word_size-1];
    end else if (amt != 5'd0) begin
      // Carry indices wrap mod 32: -amt selects bit 32-amt for LSL.
      case (bus.sft_reg[2:1])
        2'b00: begin
          b_val = src << amt;
          c_val = src[5'd0 - amt];
        end
        2'b01: begin
          b_val = src >> amt;
          c_val = src[amt - 5'd1];
        end
        2'b10: begin
          b_val = $unsigned($signed(src) >>> amt);
          c_val = src[amt - 5'd1];
        end
        default: begin
          b_val = (src >> amt) | (src << (6'd32 - {1'b0, amt}));
          c_val = src[amt - 5'd1];
        end
      endcase
    end
  end

  logic                 ex_valid_reg;
  logic [3:0]           ex_op_code_reg;
  logic [3:0]           ex_dest_reg;
  logic [word_size-1:0] ex_a_reg;
  logic [word_size-1:0] ex_b_reg;
  logic                 ex_carry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_op_code_reg <= '0;
      ex_dest_reg    <= '0;
      ex_a_reg       <= '0;
      ex_b_reg       <= '0;
      ex_carry_reg   <= 1'b0;
    end else if (!bus.ex_stall) begin
      ex_valid_reg   <= bus.in_valid;
      ex_op_code_reg <= bus.op_code;
      ex_dest_reg    <= bus.dest;
      ex_a_reg       <= a_val;
      ex_b_reg       <= b_val;
      ex_carry_reg   <= c_val;
    end
  end

  assign bus.ex_valid       = ex_valid_reg;
  assign bus.ex_op_code     = ex_op_code_reg;
  assign bus.ex_dest        = ex_dest_reg;
  assign bus.ex_a           = ex_a_reg;
  assign bus.ex_b           = ex_b_reg;
  assign bus.ex_shift_carry = ex_carry_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hand-computed vectors for reset, shifts,
// rotated immediates, bypass, stall and mid-stream reset.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.word_size(32)) bus ();

  operand_fetch #(.word_size(32), .reg_count(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one bundle on the negedge, then sample just after the next posedge.
  task automatic send(input logic v, input logic [3:0] r1, input logic ior,
                      input logic [3:0] r2, input logic [7:0] sreg,
                      input logic [3:0] simm, input logic [7:0] im,
                      input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic stall);
    @(negedge clk);
    bus.in_valid   = v;
    bus.op_code    = r1 ^ 4'h5;
    bus.dest       = r2;
    bus.op_reg1    = r1;
    bus.imm_or_reg = ior;
    bus.op_reg2    = r2;
    bus.sft_reg    = sreg;
    bus.sft_imm    = simm;
    bus.imm        = im;
    bus.wb_en      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.ex_stall   = stall;
    @(posedge clk);
    #1;
    $display("txn rst=%0b v=%0b r1=%0d r2=%0d ior=%0b sreg=%b stall=%0b wb=%0b/%0d/%h -> ex_v=%0b a=%h b=%h c=%0b",
             rst, v, r1, r2, ior, sreg, stall, we, wa, wd,
             bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_shift_carry);
  endtask

  initial begin
    rst = 1'b1;
    send(1, 4'd1, 0, 4'd1, 8'h00, 4'd0, 8'h00, 1, 4'd9, 32'h1234, 0);
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_opcode", 32'(bus.ex_op_code), 32'd0);
    check("rst_dest", 32'(bus.ex_dest), 32'd0);
    check("rst_a", bus.ex_a, 32'd0);
    check("rst_b", bus.ex_b, 32'd0);
    check("rst_carry", 32'(bus.ex_shift_carry), 32'd0);
    rst = 1'b0;

    send(1, 4'd2, 0, 4'd3, 8'h00, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("init_valid", 32'(bus.ex_valid), 32'd1);
    check("init_a", bus.ex_a, 32'd32);
    check("init_b", bus.ex_b, 32'd48);
    check("init_carry", 32'(bus.ex_shift_carry), 32'd0);
    check("init_opcode", 32'(bus.ex_op_code), 32'h7);
    check("init_dest", 32'(bus.ex_dest), 32'd3);

    send(1, 4'd2, 1, 4'd3, 8'h00, 4'd1, 8'h17, 0, 4'd0, 32'd0, 0);
    check("imm_b", bus.ex_b, 32'hC000_0005);
    check("imm_carry", 32'(bus.ex_shift_carry), 32'd1);

    send(1, 4'd2, 1, 4'd3, 8'h00, 4'd0, 8'h81, 0, 4'd0, 32'd0, 0);
    check("imm0_b", bus.ex_b, 32'h0000_0081);
    check("imm0_carry", 32'(bus.ex_shift_carry), 32'd0);

    send(1, 4'd2, 0, 4'd4, 8'b00001_010, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("lsr_b", bus.ex_b, 32'd32);
    check("lsr_carry", 32'(bus.ex_shift_carry), 32'd0);

    send(1, 4'd2, 0, 4'd15, 8'b11100_000, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("lsl_b", bus.ex_b, 32'h0000_0000);
    check("lsl_carry", 32'(bus.ex_shift_carry), 32'd1);

    send(1, 4'd2, 0, 4'd3, 8'b00101_110, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("ror_b", bus.ex_b, 32'h8000_0001);
    check("ror_carry", 32'(bus.ex_shift_carry), 32'd1);

    // Set sft_reg[0]: amount field still treated as an immediate count.
    send(1, 4'd2, 0, 4'd4, 8'b00010_001, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("lsl_bit0_b", bus.ex_b, 32'd256);

    send(0, 4'd2, 0, 4'd3, 8'h00, 4'd0, 8'h00, 1, 4'd7, 32'h8000_0000, 0);
    check("nv_valid", 32'(bus.ex_valid), 32'd0);

    send(1, 4'd2, 0, 4'd7, 8'b00100_100, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("asr_b", bus.ex_b, 32'hF800_0000);
    check("asr_carry", 32'(bus.ex_shift_carry), 32'd0);

    send(1, 4'd4, 0, 4'd4, 8'h00, 4'd0, 8'h00, 1, 4'd4, 32'd80, 0);
    check("byp_a", bus.ex_a, 32'd80);
    check("byp_b", bus.ex_b, 32'd80);

    send(1, 4'd4, 0, 4'd2, 8'h00, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("wb4_a", bus.ex_a, 32'd80);
    check("wb4_b", bus.ex_b, 32'd32);

    for (int i = 0; i < 3; i++) begin
      send(1, 4'(i + 6), 1, 4'd1, 8'h00, 4'(i + 1), 8'hFF, (i == 0), 4'd5, 32'd0, 1);
      check("stall_a", bus.ex_a, 32'd80);
      check("stall_b", bus.ex_b, 32'd32);
      check("stall_valid", 32'(bus.ex_valid), 32'd1);
      check("stall_carry", 32'(bus.ex_shift_carry), 32'd0);
    end

    send(1, 4'd5, 0, 4'd6, 8'h00, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("post_stall_a", bus.ex_a, 32'd0);
    check("post_stall_b", bus.ex_b, 32'd96);

    send(1, 4'd3, 0, 4'd3, 8'h00, 4'd0, 8'h00, 1, 4'd3, 32'd99, 0);
    check("wb3_a", bus.ex_a, 32'd99);

    rst = 1'b1;
    send(1, 4'd3, 0, 4'd3, 8'h00, 4'd0, 8'h00, 1, 4'd15, 32'd7, 1);
    check("midrst_valid", 32'(bus.ex_valid), 32'd0);
    check("midrst_a", bus.ex_a, 32'd0);
    rst = 1'b0;

    send(1, 4'd3, 0, 4'd15, 8'h00, 4'd0, 8'h00, 0, 4'd0, 32'd0, 0);
    check("rst3_a", bus.ex_a, 32'd48);
    check("rst15_b", bus.ex_b, 32'd240);
    check("rst3_valid", 32'(bus.ex_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage of the pipelined ALU, directly downstream of instruction fetch/decode. It captures decoded instruction fields, reads two source operands from a 16 x 32 register file, and forms the second operand through the barrel shifter or rotated immediate. It then presents a registered operand bundle to the execute stage. It also owns the register file write port used by writeback, with same-cycle write-to-read bypass.

## Interface
Parameters:
- word_size, 32: register and operand width.
- reg_count, 16: number of architectural registers, addressed by 4 bits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  decoded fields are valid this cycle.
- op_code  in  4  ALU operation, passed through.
- dest  in  4  destination register, passed through.
- op_reg1  in  4  first source register.
- imm_or_reg  in  1  1 selects the rotated immediate as operand B; 0 selects the shifted register.
- op_reg2  in  4  second source register.
- sft_reg  in  8  register shift control:
  - [7:3] shift amount.
  - [2:1] shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - [0] must be 0; if it is 1, the field is still treated as an immediate amount.
- sft_imm  in  4  immediate rotate count; rotate-right amount is 2*sft_imm.
- imm  in  8  immediate value.
- wb_en  in  1  writeback enable.
- wb_addr  in  4  writeback register.
- wb_data  in  32  writeback value.
- ex_stall  in  1  execute stage cannot accept; hold outputs.
- ex_valid  out  1  operand bundle valid.
- ex_op_code  out  4  registered op_code.
- ex_dest  out  4  registered dest.
- ex_a  out  32  operand A = reg[op_reg1].
- ex_b  out  32  operand B after shift/rotate.
- ex_shift_carry  out  1  last bit shifted out; 0 when the shift/rotate amount is 0.

## Operation
- Register file: 16 x 32. On rst, reg[i] = 16*i, so reg2=32, reg3=48, reg6=96 and reg15=240.
- Write: when wb_en=1 and rst=0, reg[wb_addr] takes wb_data at posedge. Writeback commits regardless of ex_stall and in_valid.
- Read bypass: if wb_en=1 and wb_addr equals op_reg1 (or op_reg2), that operand uses wb_data in the same cycle instead of the stored value.
- Operand B, immediate path (imm_or_reg=1): B = ROR({24'b0, imm}, 2*sft_imm).
- Operand B, register path (imm_or_reg=0): B = shift(reg[op_reg2], type, amount).
  - LSL and LSR fill with 0.
  - ASR fills with bit 31.
  - ROR rotates within 32 bits.
  - amount 0 means no shift for all types; there is no ARM-style "0 means 32".
- ex_shift_carry:
  - LSL: bit (32-amt) of the source.
  - LSR/ASR/ROR: bit (amt-1) of the source.
  - Immediate path: bit 31 of the result when the rotate count is nonzero.
  - 0 when the amount is 0.
- Output register:
  - ex_stall=0: loads {in_valid, op_code, dest, A, B, carry} every posedge.
  - ex_stall=1: holds all outputs; the input bundle is dropped. Upstream must hold its own PC while stalled.
- No internal FSM beyond the pipeline register. The only states are ex_valid=0/1.

## Timing
- Decode updates its fields on negedge. This stage samples them on the following posedge; half a cycle of setup is guaranteed.
- Latency: fields present at posedge N appear on ex_* after posedge N, i.e. one cycle.
- Throughput: one instruction per cycle while ex_stall=0.
- Reset: after the posedge where rst=1, the following all hold:
  - ex_valid=0, ex_op_code=0, ex_dest=0, ex_a=0, ex_b=0, ex_shift_carry=0.
  - The register file is reinitialised.
- Reset mid-operation: rst overrides stall, writeback and in_valid in the same cycle. A pending writeback in that cycle is lost.
- Simultaneous writeback and read of the same register: the bypass value is used, and the stored value updates at the same edge.
- Both sources equal to wb_addr: both are bypassed.
- in_valid=0: the bundle is still captured with ex_valid=0; the data fields are don't-care for the checker.

## Test plan
- Reset values: rst for one cycle, then op_reg1=2, op_reg2=3, imm_or_reg=0, sft_reg=0, in_valid=1 -> next cycle ex_valid=1, ex_a=32, ex_b=48, ex_shift_carry=0.
- Rotated immediate: imm_or_reg=1, imm=8'h17, sft_imm=1 -> ex_b=32'hC0000005, ex_shift_carry=1.
- LSR and ASR:
  - op_reg2=4 (64), sft_reg=8'b00001_010 -> ex_b=32, carry=0.
  - Write reg7=32'h80000000, then op_reg2=7, sft_reg=8'b00100_100 -> ex_b=32'hF8000000.
- Bypass: wb_en=1, wb_addr=4, wb_data=80 in the same cycle as op_reg1=4, op_reg2=4 -> ex_a=80, ex_b=80. A later read of reg4 returns 80.
- Stall: ex_stall=1 for 3 cycles while inputs change and wb writes reg5=0 -> ex_* frozen. After release, a read of reg5 returns 0.
- Reset mid-stream: wb writes reg3=99, then rst asserted with in_valid=1 -> ex_valid=0 next cycle, and a read of reg3 returns 48.
